// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller.
//   SEG_BLANK / DIGIT_OFF : all-off patterns for the active-low display pins
//   HEX_GLYPH             : active-low {g,f,e,d,c,b,a} glyphs for nibbles 0..F
//   scan_state_e          : scan FSM state encodings
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIGIT_OFF = 4'b1111;

  // Entry n is the glyph for nibble n (entry 15 written first).
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between the value producer and the scan controller.
//   value_in   : 16-bit hex word, [3:0] -> digit 0 (rightmost)
//   dp_in      : decimal points, bit n -> digit n, 1 = lit
//   load_valid : producer has a word to load
//   load_ready : controller can accept a word
// master = producer, slave = scan controller.
interface seven_seg_scan_ctrl_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_valid;
  logic        load_ready;

  modport master (output value_in, dp_in, load_valid, input load_ready);
  modport slave  (input value_in, dp_in, load_valid, output load_ready);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble -> active-low 7-segment glyph.
//   nibble : 4-bit value 0..F
//   seg    : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit slot lasts REFRESH_DIV cycles; the first BLANK_CYCLES of a slot
// keep every digit off to suppress ghosting. The displayed word is double
// buffered: a loaded word waits in a pending register and is copied to the
// shadow register at the frame boundary, so each frame is coherent.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   en         : 1 = scan, 0 = dark with scan position held at digit 0
//   bus        : load handshake (value_in, dp_in, load_valid, load_ready)
//   digit_sel  : active-low digit enables, bit n = digit n
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   frame_done : high for the cycle in which the digit-3 slot wraps
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  seven_seg_scan_ctrl_if.slave      bus,
  output logic [3:0]                digit_sel,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int unsigned    CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LEN = CW'(BLANK_CYCLES);

  scan_state_e   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;

  logic [15:0]   pend_val, shadow_val;
  logic [3:0]    pend_dp, shadow_dp;
  logic          load_ready_q;

  logic          frame_wrap;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [3:0]    digit_sel_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic          frame_done_d;

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // ---------------- next-state logic ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    if (!en) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      if (state == ST_IDLE) begin
        cnt_next = '0;
        idx_next = '0;
      end else if (cnt == SLOT_LAST) begin
        cnt_next = '0;
        idx_next = idx + 2'd1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
      state_next = (cnt_next < BLANK_LEN) ? ST_BLANK : ST_DRIVE;
    end
  end

  // ---------------- output decode ----------------
  assign frame_wrap = (state != ST_IDLE) && en && (idx == 2'd3) && (cnt == SLOT_LAST);
  assign nibble     = shadow_val[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    digit_sel_d = DIGIT_OFF;
    seg_d       = SEG_BLANK;
    dp_d        = 1'b1;
    // Gating with en blanks the pins on the cycle right after en falls.
    if (state == ST_DRIVE && en) begin
      digit_sel_d = ~(4'b0001 << idx);
      seg_d       = glyph;
      dp_d        = ~shadow_dp[idx];
    end
    // Registered from next-state values so the pulse lines up with the wrap cycle.
    frame_done_d = (state_next != ST_IDLE) && (idx_next == 2'd3) && (cnt_next == SLOT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel  <= DIGIT_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      digit_sel  <= digit_sel_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_done_d;
    end
  end

  // ---------------- double buffer / handshake ----------------
  // load_ready_q low means the pending register holds a word.
  // NOTE: pending and shadow registers are reset (not left uninitialised) so
  // the display shows 0000 after reset and a half-loaded word is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val     <= '0;
      pend_dp      <= '0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      load_ready_q <= 1'b1;
    end else if (!load_ready_q) begin
      if (frame_wrap || state == ST_IDLE) begin
        shadow_val   <= pend_val;
        shadow_dp    <= pend_dp;
        load_ready_q <= 1'b1;
      end
    end else if (bus.load_valid) begin
      if (frame_wrap || state == ST_IDLE) begin
        // Boundary or idle: no frame in progress to tear, bypass the pending stage.
        shadow_val <= bus.value_in;
        shadow_dp  <= bus.dp_in;
      end else begin
        pend_val     <= bus.value_in;
        pend_dp      <= bus.dp_in;
        load_ready_q <= 1'b0;
      end
    end
  end

  assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_seven_seg_scan_ctrl;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic [3:0][6:0] seg_exp;   // seg_exp[n] = expected glyph on digit n
    logic [3:0]      dp_exp;    // active-low dp expected on digit n
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] digit_sel;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[6];

  seven_seg_scan_ctrl_if bus ();

  seven_seg_scan_ctrl #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {digit_sel, seg, dp, frame_done} for visible frame position p (0..31).
  function automatic logic [12:0] exp_out(input vec_t v, input int p);
    int         d;
    int         w;
    logic       fd;
    logic [3:0] sel;
    d  = p / 8;
    w  = p % 8;
    fd = (p == 30);
    if (w < 2) return {4'b1111, 7'h7F, 1'b1, fd};
    case (d)
      0:       sel = 4'b1110;
      1:       sel = 4'b1101;
      2:       sel = 4'b1011;
      default: sel = 4'b0111;
    endcase
    return {sel, v.seg_exp[d], v.dp_exp[d], fd};
  endfunction

  // Raise en and check one whole frame starting from digit 0 BLANK.
  task automatic run_frame(input vec_t v, input string name);
    en = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check(name, {3'b0, digit_sel, seg, dp, frame_done}, {3'b0, exp_out(v, k - 1)});
    end
  endtask

  // Load a word while idle: it bypasses the pending stage, ready never drops.
  task automatic load_idle(input vec_t v);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.value_in   = v.value;
    bus.dp_in      = v.dp_in;
    @(negedge clk);
    check("idle_ready", {15'b0, bus.load_ready}, 16'd1);
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_frame_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_timeout", {15'b0, seen}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0001, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110};
    vecs[1] = '{16'hABCD, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[2] = '{16'h0008, 4'b1000, {7'h40, 7'h40, 7'h40, 7'h00}, 4'b0111};
    vecs[3] = '{16'h5679, 4'b0110, {7'h12, 7'h02, 7'h78, 7'h10}, 4'b1001};
    vecs[4] = '{16'hEF00, 4'b0101, {7'h06, 7'h0E, 7'h40, 7'h40}, 4'b1010};
    vecs[5] = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};

    rst            = 1'b1;
    en             = 1'b0;
    bus.load_valid = 1'b0;
    bus.value_in   = 16'h0000;
    bus.dp_in      = 4'b0000;
    #3;
    check("reset_outputs", {3'b0, digit_sel, seg, dp, frame_done}, {3'b0, 4'b1111, 7'h7F, 1'b1, 1'b0});
    check("reset_ready", {15'b0, bus.load_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven: load each word while idle, then scan one full frame.
    for (int i = 0; i < 6; i++) begin
      load_idle(vecs[i]);
      run_frame(vecs[i], $sformatf("table_frame%0d", i));
    end

    // Mid-frame load, held valid with changing data, boundary-cycle bypass.
    load_idle(vecs[0]);
    en = 1'b1;
    wait_frame_done();
    for (int k = 1; k <= 97; k++) begin
      int   p;
      logic exp_rdy;
      @(negedge clk);
      if (k >= 2) begin
        p = k - 2;
        check("seq_frame", {3'b0, digit_sel, seg, dp, frame_done},
              {3'b0, exp_out(vecs[p / 32], p % 32)});
      end
      exp_rdy = !(k >= 11 && k <= 32);
      check("seq_ready", {15'b0, bus.load_ready}, {15'b0, exp_rdy});
      if (k == 10) begin
        bus.load_valid = 1'b1;
        bus.value_in   = 16'hABCD;
        bus.dp_in      = 4'b0000;
      end
      if (k == 11) begin
        bus.value_in = 16'h7777;
        bus.dp_in    = 4'b1111;
      end
      if (k == 28) bus.load_valid = 1'b0;
      if (k == 64) begin
        bus.load_valid = 1'b1;
        bus.value_in   = 16'h0008;
        bus.dp_in      = 4'b1000;
      end
      if (k == 65) bus.load_valid = 1'b0;
    end

    // Drop en during the digit-2 DRIVE, then restart from digit 0.
    wait_frame_done();
    for (int k = 1; k <= 21; k++) @(negedge clk);
    check("en_drop_pre", {12'b0, digit_sel}, {12'b0, 4'b1011});
    en = 1'b0;
    @(negedge clk);
    check("en_drop_blank1", {3'b0, digit_sel, seg, dp, frame_done}, {3'b0, 4'b1111, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    check("en_drop_blank2", {3'b0, digit_sel, seg, dp, frame_done}, {3'b0, 4'b1111, 7'h7F, 1'b1, 1'b0});
    run_frame(vecs[2], "en_restart_frame");

    // Reset mid-DRIVE with a pending word: immediate blank, word discarded.
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("pre_rst_drive", {12'b0, digit_sel}, {12'b0, 4'b1110});
    bus.load_valid = 1'b1;
    bus.value_in   = 16'h4321;
    bus.dp_in      = 4'b1111;
    @(negedge clk);
    check("pre_rst_pending", {15'b0, bus.load_ready}, 16'd0);
    bus.load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {3'b0, digit_sel, seg, dp, frame_done}, {3'b0, 4'b1111, 7'h7F, 1'b1, 1'b0});
    check("rst_mid_ready", {15'b0, bus.load_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    run_frame(vecs[5], "post_rst_frame");
    check("post_rst_ready", {15'b0, bus.load_ready}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
